// File: rtl/regfile_write_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : cr16_pkg                                                         |
// | Purpose  : Shared register-file widths, types and requester indices.        |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package cr16_pkg;

  localparam int CR16_NUM_REQ = 3;
  localparam int CR16_WIDTH   = 16;
  localparam int CR16_ADDR_W  = 4;
  localparam int REG_COUNT    = 2 ** CR16_ADDR_W;

  typedef logic [CR16_ADDR_W-1:0] reg_addr_t;
  typedef logic [CR16_WIDTH-1:0]  word_t;

  typedef enum logic [1:0] {
    REQ_ALU  = 2'd0,
    REQ_LOAD = 2'd1,
    REQ_LINK = 2'd2
  } req_idx_e;

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module   : regfile_write_arbiter_if                                         |
// | Purpose  : Writeback request bus and register-bank write port bundle.       |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface regfile_write_arbiter_if
  import cr16_pkg::*;
#(
  parameter int P_NUM_REQ = CR16_NUM_REQ,
  parameter int P_WIDTH   = CR16_WIDTH,
  parameter int P_ADDR_W  = CR16_ADDR_W
);

  logic                            I_HOLD;
  logic [P_NUM_REQ-1:0]            I_REQ_VALID;
  logic [P_NUM_REQ*P_ADDR_W-1:0]   I_REQ_ADDR;
  logic [P_NUM_REQ*P_WIDTH-1:0]    I_REQ_DATA;
  logic [P_NUM_REQ-1:0]            O_REQ_READY;
  logic [(2**P_ADDR_W)-1:0]        O_REG_ENABLE;
  logic [P_WIDTH-1:0]              O_REG_DATA;
  logic [(2**P_ADDR_W)-1:0]        O_PENDING;

  // Arbiter side
  modport slave (
    input  I_HOLD, I_REQ_VALID, I_REQ_ADDR, I_REQ_DATA,
    output O_REQ_READY, O_REG_ENABLE, O_REG_DATA, O_PENDING
  );

  // Requester / bank side
  modport master (
    output I_HOLD, I_REQ_VALID, I_REQ_ADDR, I_REQ_DATA,
    input  O_REQ_READY, O_REG_ENABLE, O_REG_DATA, O_PENDING
  );

endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                       |
// | Purpose  : Round-robin one-hot grant with registered rotating pointer.      |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int P_N = 3
) (
  input  wire logic           I_CLK,
  input  wire logic           I_RESET,
  input  wire logic           i_hold,
  input  wire logic [P_N-1:0] i_valid,
  output logic      [P_N-1:0] o_grant
);

  localparam int                  C_PTR_W = (P_N > 1) ? $clog2(P_N) : 1;
  localparam logic [C_PTR_W:0]    C_N     = (C_PTR_W + 1)'(P_N);
  localparam logic [C_PTR_W-1:0]  C_LAST  = C_PTR_W'(P_N - 1);

  logic [C_PTR_W-1:0] r_ptr;
  logic [C_PTR_W-1:0] w_gnt_idx;
  logic [C_PTR_W:0]   w_sum;
  logic               w_found;

  // Scan from the pointer upward, wrapping, and take the first valid requester.
  always_comb begin
    o_grant   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    if (!I_RESET && !i_hold) begin
      for (int o = 0; o < P_N; o++) begin
        w_sum = {1'b0, r_ptr} + (C_PTR_W + 1)'(o);
        if (w_sum >= C_N) begin
          w_sum = w_sum - C_N;
        end
        if (!w_found && i_valid[w_sum[C_PTR_W-1:0]]) begin
          w_found   = 1'b1;
          w_gnt_idx = w_sum[C_PTR_W-1:0];
        end
      end
      if (w_found) begin
        o_grant[w_gnt_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + C_PTR_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : regfile_write_arbiter                                            |
// | Purpose  : Round-robin share of the register-file write port, one stage.    |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_write_arbiter
  import cr16_pkg::*;
#(
  parameter int P_NUM_REQ = CR16_NUM_REQ,
  parameter int P_WIDTH   = CR16_WIDTH,
  parameter int P_ADDR_W  = CR16_ADDR_W
) (
  input wire logic               I_CLK,
  input wire logic               I_RESET,
  regfile_write_arbiter_if.slave bus
);

  localparam int C_REG_COUNT = 2 ** P_ADDR_W;

  logic [P_NUM_REQ-1:0]   w_grant;
  logic                   w_transfer;
  logic [P_ADDR_W-1:0]    w_sel_addr;
  logic [P_WIDTH-1:0]     w_sel_data;
  logic [C_REG_COUNT-1:0] w_dec;
  logic [C_REG_COUNT-1:0] r_enable;
  logic [P_WIDTH-1:0]     r_data;

  rr_arbiter #(
    .P_N (P_NUM_REQ)
  ) u_arb (
    .I_CLK   (I_CLK),
    .I_RESET (I_RESET),
    .i_hold  (bus.I_HOLD),
    .i_valid (bus.I_REQ_VALID),
    .o_grant (w_grant)
  );

  assign bus.O_REQ_READY = w_grant;
  assign w_transfer      = |(w_grant & bus.I_REQ_VALID);

  // Grant is one-hot, so selecting the winner's slice is a simple priority-free mux.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = bus.I_REQ_ADDR[i*P_ADDR_W +: P_ADDR_W];
        w_sel_data = bus.I_REQ_DATA[i*P_WIDTH +: P_WIDTH];
      end
    end
  end

  assign w_dec = C_REG_COUNT'(1) << w_sel_addr;

  // Hold freezes the stage so the bank simply rewrites the same value.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_enable <= '0;
      r_data   <= '0;
    end else if (!bus.I_HOLD) begin
      if (w_transfer) begin
        r_enable <= w_dec;
        r_data   <= w_sel_data;
      end else begin
        r_enable <= '0;
      end
    end
  end

  assign bus.O_REG_ENABLE = r_enable;
  assign bus.O_REG_DATA   = r_data;
  assign bus.O_PENDING    = r_enable;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_write_arbiter                                         |
// | Purpose  : Directed self-checking bench with a behavioural arbiter model.   |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_write_arbiter;
  import cr16_pkg::*;

  logic clk;
  logic rst;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Behavioural model state
  int    m_ptr;
  bit    m_vld;
  int    m_addr;
  word_t m_data;
  word_t m_bank [REG_COUNT];

  // Bank driven by the DUT's write port
  word_t d_bank [REG_COUNT];

  logic [2:0] last_rdy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (bus.O_REG_ENABLE[r]) d_bank[r] <= bus.O_REG_DATA;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check READY, advance model on the edge, check the stage.
  task automatic cycle(input logic r, input logic h, input logic [2:0] v,
                       input reg_addr_t a0, input reg_addr_t a1, input reg_addr_t a2,
                       input word_t d0, input word_t d1, input word_t d2);
    reg_addr_t a [3];
    word_t     d [3];
    int        g;
    logic [15:0] exp_en;
    a[0] = a0; a[1] = a1; a[2] = a2;
    d[0] = d0; d[1] = d1; d[2] = d2;
    rst             = r;
    bus.I_HOLD      = h;
    bus.I_REQ_VALID = v;
    bus.I_REQ_ADDR  = {a2, a1, a0};
    bus.I_REQ_DATA  = {d2, d1, d0};
    g = -1;
    if (!r && !h) begin
      for (int o = 0; o < 3; o++) begin
        if (g < 0 && v[(m_ptr + o) % 3]) g = (m_ptr + o) % 3;
      end
    end
    #1;
    last_rdy = bus.O_REQ_READY;
    chk("ready", {29'd0, bus.O_REQ_READY}, (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (r) begin
      m_vld  = 1'b0;
      m_data = '0;
      m_ptr  = 0;
    end else begin
      if (m_vld) m_bank[m_addr] = m_data;
      if (!h) begin
        if (g >= 0) begin
          m_vld  = 1'b1;
          m_addr = int'(a[g]);
          m_data = d[g];
          m_ptr  = (g + 1) % 3;
        end else begin
          m_vld = 1'b0;
        end
      end
    end
    #1;
    exp_en = m_vld ? (16'd1 << m_addr) : 16'd0;
    chk("enable",  {16'd0, bus.O_REG_ENABLE}, {16'd0, exp_en});
    chk("data",    {16'd0, bus.O_REG_DATA},   {16'd0, m_data});
    chk("pending", {16'd0, bus.O_PENDING},    {16'd0, exp_en});
  endtask

  task automatic idle(input logic r);
    cycle(r, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [2:0] rr_exp [6];
    total = 0;
    bad   = 0;
    m_ptr = 0; m_vld = 1'b0; m_addr = 0; m_data = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      m_bank[r] = '0;
      d_bank[r] = '0;
    end
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
    rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

    // Reset with everyone requesting: READY must stay low
    cycle(1'b1, 1'b0, 3'b111, 4'd1, 4'd2, 4'd3, 16'h1, 16'h2, 16'h3);
    chk("reset_ready", {29'd0, last_rdy}, 32'd0);
    idle(1'b1);
    chk("reset_enable", {16'd0, bus.O_REG_ENABLE}, 32'd0);
    chk("reset_data",   {16'd0, bus.O_REG_DATA},   32'd0);

    // Reset mid-write: ALU r3 captured, then reset discards it
    cycle(1'b0, 1'b0, 3'b001, 4'd3, 4'd0, 4'd0, 16'h1234, 16'h0, 16'h0);
    chk("midwr_enable", {16'd0, bus.O_REG_ENABLE}, 32'h0008);
    idle(1'b1);
    chk("midwr_enable_rst",  {16'd0, bus.O_REG_ENABLE}, 32'd0);
    chk("midwr_pending_rst", {16'd0, bus.O_PENDING},    32'd0);
    idle(1'b0);
    chk("midwr_bank_r3", {16'd0, d_bank[3]}, 32'd0);

    // Single ALU write r5
    cycle(1'b0, 1'b0, 3'b001, 4'd5, 4'd0, 4'd0, 16'hBEEF, 16'h0, 16'h0);
    chk("single_ready",  {29'd0, last_rdy}, 32'b001);
    chk("single_enable", {16'd0, bus.O_REG_ENABLE}, 32'h0020);
    chk("single_data",   {16'd0, bus.O_REG_DATA},   32'hBEEF);
    idle(1'b0);
    chk("single_drain", {16'd0, bus.O_REG_ENABLE}, 32'd0);
    chk("single_hold_data", {16'd0, bus.O_REG_DATA}, 32'hBEEF);
    idle(1'b0);
    chk("single_bank_r5", {16'd0, d_bank[5]}, 32'hBEEF);

    // Round-robin from pointer 0, all three valid every cycle
    idle(1'b1);
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 1'b0, 3'b111, 4'(8 + c), 4'(c), 4'(15 - c),
            16'h1000 + 16'(c), 16'h2000 + 16'(c), 16'h3000 + 16'(c));
      chk("rr_grant", {29'd0, last_rdy}, {29'd0, rr_exp[c]});
    end

    // Fairness after skip: pointer to 1, then only requesters 0 and 2
    cycle(1'b0, 1'b0, 3'b001, 4'd1, 4'd0, 4'd0, 16'h0101, 16'h0, 16'h0);
    cycle(1'b0, 1'b0, 3'b101, 4'd4, 4'd0, 4'd6, 16'h0404, 16'h0, 16'h0606);
    chk("fair_grant_2", {29'd0, last_rdy}, 32'b100);
    cycle(1'b0, 1'b0, 3'b001, 4'd4, 4'd0, 4'd0, 16'h0404, 16'h0, 16'h0);
    chk("fair_grant_0", {29'd0, last_rdy}, 32'b001);
    cycle(1'b0, 1'b0, 3'b111, 4'd9, 4'd10, 4'd11, 16'h0909, 16'h0A0A, 16'h0B0B);
    chk("fair_ptr_1", {29'd0, last_rdy}, 32'b010);

    // Hold: stage carries r7=0x00FF across three frozen cycles
    cycle(1'b0, 1'b0, 3'b001, 4'd7, 4'd0, 4'd0, 16'h00FF, 16'h0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b1, 3'b111, 4'd12, 4'd13, 4'd14, 16'hC0C0, 16'hD0D0, 16'hE0E0);
      chk("hold_ready",  {29'd0, last_rdy}, 32'd0);
      chk("hold_enable", {16'd0, bus.O_REG_ENABLE}, 32'h0080);
      chk("hold_data",   {16'd0, bus.O_REG_DATA},   32'h00FF);
    end
    cycle(1'b0, 1'b0, 3'b111, 4'd12, 4'd13, 4'd14, 16'hC0C0, 16'hD0D0, 16'hE0E0);
    chk("hold_release", {29'd0, last_rdy}, 32'b010);

    // Same target r2: pointer to 1, LOAD then LINK, later grant wins
    cycle(1'b0, 1'b0, 3'b001, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0, 16'h0);
    cycle(1'b0, 1'b0, 3'b110, 4'd0, 4'd2, 4'd2, 16'h0, 16'hAAAA, 16'h5555);
    chk("same_load", {29'd0, last_rdy}, 32'b010);
    cycle(1'b0, 1'b0, 3'b100, 4'd0, 4'd2, 4'd2, 16'h0, 16'hAAAA, 16'h5555);
    chk("same_link", {29'd0, last_rdy}, 32'b100);
    idle(1'b0);
    idle(1'b0);
    chk("same_bank_r2",   {16'd0, d_bank[2]}, 32'h5555);
    chk("model_bank_r2",  {16'd0, m_bank[2]}, 32'h5555);
    for (int r = 0; r < REG_COUNT; r++) begin
      chk("bank_match", {16'd0, d_bank[r]}, {16'd0, m_bank[r]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
